// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and width default for the ALU responder
//
// Purpose: common definitions imported by alu_req_responder and alu_seq_multiplier.
// Contents: ALU_WIDTH default, ALU_* opcode codes, alu_state_t FSM encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_MULTU = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_XOR   = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - iterative shift-add unsigned multiplier
//
// Purpose: one shift-add step per cycle; o_done pulses for one cycle after
//          MUL_CYCLES steps, with o_product valid from then until the next start.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_start          load operands and begin (ignored state is discarded)
//   i_a, i_b         WIDTH-bit unsigned operands
//   o_done           one-cycle pulse when the product is complete
//   o_product        2*WIDTH-bit product
module alu_seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_acc    <= '0;
                r_count  <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                // Add the shifted multiplicand for each set multiplier bit, LSB first.
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
                if (r_count == CW'(MUL_CYCLES - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_req_responder.sv
// rtl/alu_req_responder.sv - handshaked registered ALU execution responder
//
// Purpose: accepts {ALUctl, A, B} on a valid/ready request channel, computes the
//          result and flags, and returns them on a valid/ready response channel.
// Option:  ALU_RESP_MULT_EN builds the iterative MULTU path (MUL state and
//          alu_seq_multiplier); without it opcode 0011 is reported as unsupported.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_ALUctl, req_A, req_B        opcode and operands
//   resp_valid/resp_ready           response handshake
//   resp_result                     result
//   resp_Zero, resp_carryFlag,
//   resp_overflowFlag, resp_err     result flags
module alu_req_responder
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_ALUctl,
    input  logic [WIDTH-1:0] req_A,
    input  logic [WIDTH-1:0] req_B,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_Zero,
    output logic             resp_carryFlag,
    output logic             resp_overflowFlag,
    output logic             resp_err
);

    if (MUL_CYCLES != WIDTH) begin : g_bad_cfg
        $error("alu_req_responder: MUL_CYCLES must equal WIDTH");
    end

    alu_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_carry, r_ovf, r_err;

    logic             w_req_ready, w_accept, w_is_mul, w_load_alu;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry, w_alu_ovf, w_alu_err;
    logic [WIDTH:0]   w_sum, w_diff;

`ifdef ALU_RESP_MULT_EN
    logic               w_start, w_load_mul, w_mul_done;
    logic [2*WIDTH-1:0] w_product;

    alu_seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_a       (req_A),
        .i_b       (req_B),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign w_is_mul = (req_ALUctl == ALU_MULTU);
`else
    assign w_is_mul = 1'b0;
`endif

    // Ready in IDLE, or in RESP when the current response drains this cycle.
    assign w_req_ready = !reset && ((r_state == IDLE) || ((r_state == RESP) && resp_ready));
    assign w_accept    = req_valid && w_req_ready;

    assign w_sum  = {1'b0, req_A} + {1'b0, req_B};
    assign w_diff = {1'b0, req_A} - {1'b0, req_B};

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_err   = 1'b0;
        case (req_ALUctl)
            ALU_AND: w_alu_res = req_A & req_B;
            ALU_OR:  w_alu_res = req_A | req_B;
            ALU_NOR: w_alu_res = ~(req_A | req_B);
            ALU_XOR: w_alu_res = req_A ^ req_B;
            ALU_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (req_A[WIDTH-1] == req_B[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != req_A[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                // Borrow out of the extended subtract means A < B; carry is its inverse.
                w_alu_carry = !w_diff[WIDTH];
                w_alu_ovf   = (req_A[WIDTH-1] != req_B[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != req_A[WIDTH-1]);
            end
            ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_A) < $signed(req_B))};
            default: w_alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load_alu = 1'b0;
`ifdef ALU_RESP_MULT_EN
        w_start    = 1'b0;
        w_load_mul = 1'b0;
`endif
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_next = MUL;
`ifdef ALU_RESP_MULT_EN
                        w_start = 1'b1;
`endif
                    end else begin
                        w_next     = RESP;
                        w_load_alu = 1'b1;
                    end
                end else if (r_state == RESP && resp_ready) begin
                    w_next = IDLE;
                end
            end
`ifdef ALU_RESP_MULT_EN
            MUL: begin
                if (w_mul_done) begin
                    w_next     = RESP;
                    w_load_mul = 1'b1;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load_alu) begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
            r_carry  <= w_alu_carry;
            r_ovf    <= w_alu_ovf;
            r_err    <= w_alu_err;
        end
`ifdef ALU_RESP_MULT_EN
        else if (w_load_mul) begin
            r_result <= w_product[WIDTH-1:0];
            r_zero   <= (w_product[WIDTH-1:0] == '0);
            r_carry  <= |w_product[2*WIDTH-1:WIDTH];
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end
`endif
    end

    assign req_ready         = w_req_ready;
    assign resp_valid        = (r_state == RESP);
    assign resp_result       = r_result;
    assign resp_Zero         = r_zero;
    assign resp_carryFlag    = r_carry;
    assign resp_overflowFlag = r_ovf;
    assign resp_err          = r_err;

endmodule

// File: tb/tb_alu_req_responder.sv
// tb/tb_alu_req_responder.sv - directed self-checking bench for alu_req_responder
module tb_alu_req_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ALUctl;
    logic [31:0] req_A;
    logic [31:0] req_B;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_Zero;
    logic        resp_carryFlag;
    logic        resp_overflowFlag;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ALU_RESP_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    alu_req_responder dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_ALUctl        (req_ALUctl),
        .req_A             (req_A),
        .req_B             (req_B),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_result       (resp_result),
        .resp_Zero         (resp_Zero),
        .resp_carryFlag    (resp_carryFlag),
        .resp_overflowFlag (resp_overflowFlag),
        .resp_err          (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {resp_Zero, resp_carryFlag, resp_overflowFlag, resp_err};
    endfunction

    // Issue one request from IDLE with resp_ready=1; flags are packed {Z,C,O,E}.
    task automatic run_op(input string tag, input logic [3:0] ctl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags,
                          input int exp_lat);
        int n;
        logic rdy_seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_ALUctl = ctl;
        req_A      = a;
        req_B      = b;
        check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        rdy_seen = 1'b0;
        while (!resp_valid && n < 100) begin
            if (req_ready) rdy_seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        if (exp_lat > 0) check({tag, ".busy_ready"}, 64'(rdy_seen), 64'd0);
        check({tag, ".result"}, 64'(resp_result), 64'(exp_res));
        check({tag, ".flags"}, 64'(flags()), 64'(exp_flags));
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_ALUctl = 4'h0;
        req_A      = '0;
        req_B      = '0;
        resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.req_ready", 64'(req_ready), 64'd0);
        check("reset.resp_valid", 64'(resp_valid), 64'd0);
        check("reset.result", 64'(resp_result), 64'd0);
        check("reset.flags", 64'(flags()), 64'd0);
        reset = 1'b0;
        #1;
        check("idle.req_ready", 64'(req_ready), 64'd1);

        run_op("and",  4'b0000, 32'h1010F00C, 32'h040F0E0C, 32'h0000000C, 4'b0000, 0);
        run_op("or",   4'b0001, 32'h1010F00C, 32'h040F0E0C, 32'h141FFE0C, 4'b0000, 0);
        run_op("add1", 4'b0010, 32'hFFFFFFFE, 32'h10000001, 32'h0FFFFFFF, 4'b0100, 0);
        run_op("add2", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0010, 0);
        run_op("sub1", 4'b0110, 32'h0FFFFFFB, 32'hFFFFFFFE, 32'h0FFFFFFD, 4'b0000, 0);
        run_op("sub2", 4'b0110, 32'h12345678, 32'h12345678, 32'h00000000, 4'b1100, 0);
        run_op("slt1", 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 0);
        run_op("slt2", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 0);
        run_op("nor",  4'b1100, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 4'b0000, 0);
        run_op("xor",  4'b1101, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b0000, 0);
        run_op("bad",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b1001, 0);

        if (MULT_EN) begin
            run_op("mul1", 4'b0011, 32'h0FFFFFFF, 32'h00000004, 32'h3FFFFFFC, 4'b0000, 33);
            run_op("mul2", 4'b0011, 32'h80000000, 32'h00000002, 32'h00000000, 4'b1100, 33);
        end else begin
            run_op("mul_off", 4'b0011, 32'h0FFFFFFF, 32'h00000004, 32'h00000000, 4'b1001, 0);
        end

        // Backpressure: response held for 5 cycles, then a back-to-back XOR issue.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_ALUctl = 4'b0000;
        req_A      = 32'h1010F00C;
        req_B      = 32'h040F0E0C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        begin
            logic stable_bad;
            stable_bad = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (!resp_valid || req_ready || resp_result != 32'h0000000C) stable_bad = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            if (!resp_valid || req_ready || resp_result != 32'h0000000C) stable_bad = 1'b1;
            check("bp.stable", 64'(stable_bad), 64'd0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_ALUctl = 4'b1101;
        req_A      = 32'hFFFF0000;
        req_B      = 32'h0F0F0F0F;
        #1;
        check("bp.req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp.resp_valid", 64'(resp_valid), 64'd1);
        check("bp.result", 64'(resp_result), 64'hF0F00F0F);
        @(posedge clk);
        @(negedge clk);
        check("bp.drained", 64'(resp_valid), 64'd0);

        // Reset mid-operation: MULTU on cycle 10 when built, otherwise a held response.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_ALUctl = MULT_EN ? 4'b0011 : 4'b0010;
        req_A      = 32'h0FFFFFFF;
        req_B      = 32'h00000004;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst.req_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd1);
        resp_ready = 1'b1;
        begin
            logic stray;
            stray = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (resp_valid) stray = 1'b1;
            end
            check("rst.no_stray_resp", 64'(stray), 64'd0);
        end

        run_op("post_rst", 4'b0010, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
